// File: rtl/paddsub_arb_if.sv
// Requester/response bundle for paddsub_arb: two operand-pair request ports and one result port.
// rsp_sat exists only when PADDSUB_ARB_SATFLAG_EN is defined.
interface paddsub_arb_if;
   logic        req0_valid;
   logic [15:0] req0_opa;
   logic [15:0] req0_opb;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_opa;
   logic [15:0] req1_opb;
   logic        req1_ready;
   logic        rsp_valid;
   logic        rsp_id;
   logic [15:0] rsp_data;
`ifdef PADDSUB_ARB_SATFLAG_EN
   logic [3:0]  rsp_sat;
`endif
   logic        rsp_ready;

   modport master (
      output req0_valid, req0_opa, req0_opb,
      input  req0_ready,
      output req1_valid, req1_opa, req1_opb,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_data,
`ifdef PADDSUB_ARB_SATFLAG_EN
      input  rsp_sat,
`endif
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_opa, req0_opb,
      output req0_ready,
      input  req1_valid, req1_opa, req1_opb,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_data,
`ifdef PADDSUB_ARB_SATFLAG_EN
      output rsp_sat,
`endif
      input  rsp_ready
   );
endinterface

// File: rtl/paddsub_arb.sv
// Round-robin arbiter + 2-stage pipeline in front of a shared 4x4-bit signed saturating adder.
// Optional per-lane saturation flags on rsp_sat when PADDSUB_ARB_SATFLAG_EN is defined.

module paddsub (
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   output logic [15:0] sum
);
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [3:0] a_lane;
         logic [3:0] b_lane;
         logic [3:0] raw_lane;
         logic       ovf_lane;
         assign a_lane   = opa[4*gi +: 4];
         assign b_lane   = opb[4*gi +: 4];
         assign raw_lane = a_lane + b_lane;
         assign ovf_lane = (a_lane[3] == b_lane[3]) && (raw_lane[3] != a_lane[3]);
         assign sum[4*gi +: 4] = ovf_lane ? (a_lane[3] ? 4'h8 : 4'h7) : raw_lane;
      end
   endgenerate
endmodule

module paddsub_arb (
   input  logic           clk,
   input  logic           rst_n,
   paddsub_arb_if.slave   bus
);
   logic        last_reg;
   logic        s1_valid_reg;
   logic        s1_id_reg;
   logic [15:0] s1_opa_reg;
   logic [15:0] s1_opb_reg;
   logic        s2_valid_reg;
   logic        s2_id_reg;
   logic [15:0] s2_data_reg;

   logic        s2_free;
   logic        s1_free;
   logic        grant;
   logic        hs0;
   logic        hs1;
   logic        load;
   logic        advance;
   logic [15:0] sum;

   always_comb begin
      s2_free = !s2_valid_reg || bus.rsp_ready;
      s1_free = !s1_valid_reg || s2_free;
      // Contention goes to whoever did not win last; a lone requester always wins.
      if (bus.req0_valid && bus.req1_valid) grant = !last_reg;
      else                                  grant = bus.req1_valid;
      hs0     = bus.req0_valid && s1_free && !grant;
      hs1     = bus.req1_valid && s1_free && grant;
      load    = hs0 || hs1;
      advance = s1_valid_reg && s2_free;
   end

   assign bus.req0_ready = s1_free && !grant;
   assign bus.req1_ready = s1_free && grant;

   paddsub u_paddsub (
      .opa (s1_opa_reg),
      .opb (s1_opb_reg),
      .sum (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg     <= 1'b1;
         s1_valid_reg <= 1'b0;
         s1_id_reg    <= 1'b0;
         s1_opa_reg   <= 16'h0000;
         s1_opb_reg   <= 16'h0000;
      end else begin
         if (load) begin
            s1_valid_reg <= 1'b1;
            s1_id_reg    <= grant;
            s1_opa_reg   <= grant ? bus.req1_opa : bus.req0_opa;
            s1_opb_reg   <= grant ? bus.req1_opb : bus.req0_opb;
            last_reg     <= grant;
         end else if (s2_free) begin
            s1_valid_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         s2_id_reg    <= 1'b0;
         s2_data_reg  <= 16'h0000;
      end else begin
         if (advance) begin
            s2_valid_reg <= 1'b1;
            s2_id_reg    <= s1_id_reg;
            s2_data_reg  <= sum;
         end else if (bus.rsp_ready) begin
            s2_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid = s2_valid_reg;
   assign bus.rsp_id    = s2_id_reg;
   assign bus.rsp_data  = s2_data_reg;

`ifdef PADDSUB_ARB_SATFLAG_EN
   logic [3:0] s1_ovf;
   logic [3:0] s2_sat_reg;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ovf
         logic [3:0] raw_lane;
         assign raw_lane   = s1_opa_reg[4*gi +: 4] + s1_opb_reg[4*gi +: 4];
         assign s1_ovf[gi] = (s1_opa_reg[4*gi+3] == s1_opb_reg[4*gi+3]) &&
                             (raw_lane[3] != s1_opa_reg[4*gi+3]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       s2_sat_reg <= 4'h0;
      else if (advance) s2_sat_reg <= s1_ovf;
   end

   assign bus.rsp_sat = s2_sat_reg;
`endif
endmodule

// File: tb/tb_paddsub_arb.sv
// Directed bench for paddsub_arb: saturation, round-robin, backpressure, streaming, async reset.
module tb_paddsub_arb;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   test_cnt = 0;
   int   fail_cnt = 0;

   paddsub_arb_if bus_if ();

   paddsub_arb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      test_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, act);
      end
   endtask

   task automatic set_req(input int n, input logic v, input logic [15:0] a, input logic [15:0] b);
      if (n == 0) begin
         bus_if.req0_valid = v;
         bus_if.req0_opa   = a;
         bus_if.req0_opb   = b;
      end else begin
         bus_if.req1_valid = v;
         bus_if.req1_opa   = a;
         bus_if.req1_opb   = b;
      end
   endtask

   task automatic idle();
      set_req(0, 1'b0, 16'h0, 16'h0);
      set_req(1, 1'b0, 16'h0, 16'h0);
      bus_if.rsp_ready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  n;
      int  m;
      int  hs_cnt;
      int  rcnt;
      logic hs;

      idle();
      #1 rst_n = 1'b0;
      #2;
      check("reset_rsp_valid", 16'(bus_if.rsp_valid), 16'h0);
      check("reset_rsp_id",    16'(bus_if.rsp_id),    16'h0);
      check("reset_rsp_data",  bus_if.rsp_data,       16'h0000);
`ifdef PADDSUB_ARB_SATFLAG_EN
      check("reset_rsp_sat",   16'(bus_if.rsp_sat),   16'h0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Positive saturation in lane 3
      @(negedge clk);
      set_req(0, 1'b1, 16'h7F11, 16'h1122);
      #1 check("t1_req0_ready", 16'(bus_if.req0_ready), 16'h1);
      @(negedge clk);
      set_req(0, 1'b0, 16'h0, 16'h0);
      #1 check("t1_rsp_valid_early", 16'(bus_if.rsp_valid), 16'h0);
      @(negedge clk);
      #1;
      check("t1_rsp_valid", 16'(bus_if.rsp_valid), 16'h1);
      check("t1_rsp_id",    16'(bus_if.rsp_id),    16'h0);
      check("t1_rsp_data",  bus_if.rsp_data,       16'h7033);
`ifdef PADDSUB_ARB_SATFLAG_EN
      check("t1_rsp_sat",   16'(bus_if.rsp_sat),   16'h8);
`endif

      // Negative saturation in every lane
      @(negedge clk);
      set_req(1, 1'b1, 16'h8888, 16'h8888);
      #1 check("t2_req1_ready", 16'(bus_if.req1_ready), 16'h1);
      @(negedge clk);
      set_req(1, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      #1;
      check("t2_rsp_valid", 16'(bus_if.rsp_valid), 16'h1);
      check("t2_rsp_id",    16'(bus_if.rsp_id),    16'h1);
      check("t2_rsp_data",  bus_if.rsp_data,       16'h8888);
`ifdef PADDSUB_ARB_SATFLAG_EN
      check("t2_rsp_sat",   16'(bus_if.rsp_sat),   16'hF);
`endif

      // Round-robin from reset, both requesters continuously valid
      do_reset();
      set_req(0, 1'b1, 16'h1111, 16'h0000);
      set_req(1, 1'b1, 16'h2222, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         #1;
         check($sformatf("t3_ready0_k%0d", k), 16'(bus_if.req0_ready), 16'((k % 2) == 0));
         check($sformatf("t3_ready1_k%0d", k), 16'(bus_if.req1_ready), 16'((k % 2) == 1));
         if (k >= 2) begin
            check($sformatf("t3_rsp_valid_k%0d", k), 16'(bus_if.rsp_valid), 16'h1);
            check($sformatf("t3_rsp_id_k%0d", k),    16'(bus_if.rsp_id),    16'((k - 2) % 2));
            check($sformatf("t3_rsp_data_k%0d", k),  bus_if.rsp_data,
                  ((k - 2) % 2 == 1) ? 16'h2222 : 16'h1111);
         end
         @(negedge clk);
      end
      idle();
      repeat (3) @(negedge clk);

      // Backpressure: req0 streams n+n while the consumer stalls for 5 cycles
      bus_if.rsp_ready = 1'b0;
      n = 1;
      hs_cnt = 0;
      set_req(0, 1'b1, 16'(n), 16'(n));
      for (int k = 0; k < 5; k++) begin
         #1;
         hs = bus_if.req0_valid && bus_if.req0_ready;
         if (hs) hs_cnt++;
         @(negedge clk);
         if (hs) begin
            n++;
            set_req(0, n <= 3, 16'(n), 16'(n));
         end
      end
      #1;
      check("t4_handshakes",   16'(hs_cnt),            16'd2);
      check("t4_req0_ready",   16'(bus_if.req0_ready), 16'h0);
      check("t4_rsp_valid",    16'(bus_if.rsp_valid),  16'h1);
      check("t4_rsp_data_hold", bus_if.rsp_data,       16'h0002);
      bus_if.rsp_ready = 1'b1;
      m = 1;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (bus_if.rsp_valid) begin
            check($sformatf("t4_rsp_data_%0d", m), bus_if.rsp_data, 16'(2 * m));
            m++;
         end
         hs = bus_if.req0_valid && bus_if.req0_ready;
         @(negedge clk);
         if (hs) begin
            n++;
            set_req(0, n <= 3, 16'(n), 16'(n));
         end
      end
      check("t4_rsp_count", 16'(m - 1), 16'd3);
      idle();
      @(negedge clk);

      // Single requester streaming: req1 alone for 8 cycles
      rcnt = 0;
      set_req(1, 1'b1, 16'h0000, 16'h0000);
      for (int k = 0; k < 12; k++) begin
         #1;
         if (k < 8) check($sformatf("t5_req1_ready_k%0d", k), 16'(bus_if.req1_ready), 16'h1);
         if (bus_if.rsp_valid) begin
            check($sformatf("t5_rsp_id_%0d", rcnt),   16'(bus_if.rsp_id), 16'h1);
            check($sformatf("t5_rsp_data_%0d", rcnt), bus_if.rsp_data,    16'(rcnt));
            rcnt++;
         end
         @(negedge clk);
         set_req(1, k < 7, 16'(k + 1), 16'h0000);
      end
      check("t5_rsp_count", 16'(rcnt), 16'd8);
      idle();
      @(negedge clk);

      // Reset with both stages full; last pointer left at 0 beforehand
      bus_if.rsp_ready = 1'b0;
      set_req(0, 1'b1, 16'h0101, 16'h0101);
      repeat (2) @(negedge clk);
      set_req(1, 1'b1, 16'h0202, 16'h0202);
      #1;
      check("t6_rsp_valid_pre", 16'(bus_if.rsp_valid),  16'h1);
      check("t6_req_ready_pre", 16'(bus_if.req1_ready), 16'h0);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rsp_valid_async", 16'(bus_if.rsp_valid),  16'h0);
      check("t6_rst_ready0",      16'(bus_if.req0_ready), 16'h1);
      check("t6_rst_ready1",      16'(bus_if.req1_ready), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.rsp_ready = 1'b1;
      #1;
      check("t6_post_ready0", 16'(bus_if.req0_ready), 16'h1);
      check("t6_post_ready1", 16'(bus_if.req1_ready), 16'h0);
      @(negedge clk);
      #1;
      check("t6_next_ready1", 16'(bus_if.req1_ready), 16'h1);
      check("t6_next_rsp_valid", 16'(bus_if.rsp_valid), 16'h0);
      idle();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end
endmodule
